// File: rtl/sram_arb_pkg.sv
// Shared constants, size encodings and a width helper for the SRAM-like channel arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int DEF_NCH   = 2;
    localparam int DEF_AW    = 32;
    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_RR    = 1;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of channel indices for accepted requests; head names who owns the next response.
module tag_fifo
    import sram_arb_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          push,
    input  logic [W-1:0]                  push_data,
    input  logic                          pop,
    output logic [W-1:0]                  pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full     = (int'(count_q) == DEPTH);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = bump(wr_ptr_q);
        if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only meaningful while count says so.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates NCH SRAM-like channels onto one downstream port; responses return in request order.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int RR    = DEF_RR
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NCH-1:0]              s_req,
    input  logic [NCH-1:0]              s_wr,
    input  logic [2*NCH-1:0]            s_size,
    input  logic [(DW/8)*NCH-1:0]       s_wstrb,
    input  logic [AW*NCH-1:0]           s_addr,
    input  logic [DW*NCH-1:0]           s_wdata,
    output logic [NCH-1:0]              s_addr_ok,
    output logic [NCH-1:0]              s_data_ok,
    output logic [DW-1:0]               s_rdata,
    output logic                        m_req,
    output logic                        m_wr,
    output logic [1:0]                  m_size,
    output logic [DW/8-1:0]             m_wstrb,
    output logic [AW-1:0]               m_addr,
    output logic [DW-1:0]               m_wdata,
    input  logic                        m_addr_ok,
    input  logic                        m_data_ok,
    input  logic [DW-1:0]               m_rdata,
    output logic [clog2(DEPTH+1)-1:0]   outstanding,
    output logic                        resp_err
);

    localparam int IW = (NCH > 1) ? clog2(NCH) : 1;
    localparam int SW = DW / 8;

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic          lock_q, lock_d;
    logic          resp_err_q, resp_err_d;
    logic [IW-1:0] arb_idx, grant, head;
    logic          arb_found;
    int            cand;
    int            grant_i;
    logic          fifo_full, fifo_empty, handshake, pop;

    // Search starts at rr_ptr in round-robin mode, at channel 0 in fixed mode.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = 0;
        for (int i = 0; i < NCH; i++) begin
            cand = (RR != 0) ? (int'(rr_ptr_q) + i) % NCH : i;
            if (!arb_found && s_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = IW'(cand);
            end
        end
    end

    // A held lock wins only while its channel still requests; otherwise arbitration reruns now.
    assign grant     = (lock_q && s_req[lock_idx_q]) ? lock_idx_q : arb_idx;
    assign grant_i   = int'(grant);
    assign m_req     = resetn && (|s_req) && !fifo_full;
    assign handshake = m_req && m_addr_ok;
    assign pop       = m_data_ok && !fifo_empty;

    always_comb begin
        m_wr      = s_wr[grant_i];
        m_size    = s_size[2*grant_i +: 2];
        m_wstrb   = s_wstrb[SW*grant_i +: SW];
        m_addr    = s_addr[AW*grant_i +: AW];
        m_wdata   = s_wdata[DW*grant_i +: DW];
        s_addr_ok = '0;
        s_data_ok = '0;
        s_rdata   = '0;
        if (handshake) s_addr_ok[grant_i] = 1'b1;
        if (pop) begin
            s_data_ok[head] = 1'b1;
            s_rdata         = m_rdata;
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        if (handshake) rr_ptr_d = (grant_i == NCH - 1) ? '0 : grant + 1'b1;
        lock_d     = m_req && !m_addr_ok;
        lock_idx_d = grant;
        resp_err_d = resp_err_q || (m_data_ok && fifo_empty);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err = resp_err_q;

    tag_fifo #(.W(IW), .DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (handshake),
        .push_data (grant),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

endmodule
